// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Imported by the arbiter top and its watchdog.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] DL_BYTE  = 2'b00;
  localparam logic [1:0] DL_HALF  = 2'b01;
  localparam logic [1:0] DL_WORD  = 2'b10;
  localparam logic [1:0] DL_DWORD = 2'b11;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/memory_arbiter_watchdog.sv
// ACCESS-phase watchdog: clear/increment counter whose flag marks
// the last cycle in which a RAM completion is still accepted.
module memory_arbiter_watchdog
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic main_clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  // Counter holds the number of elapsed wait cycles, so the
  // TIMEOUT-th ACCESS cycle sees a value of TIMEOUT-1.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter between a fetch port and a data port
// sharing one RAM command interface; all outputs registered.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        main_clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [8:0]  if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_dl,
  input  logic [8:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        busy,
  output logic        ram_mov,
  output logic        ram_rw,
  output logic [1:0]  ram_dl,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_moc,
  input  logic [31:0] ram_rdata
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        w_last_grant_nxt;
  logic        r_winner;
  logic        w_winner_nxt;
  logic        w_grant;

  logic        r_ram_mov;
  logic        r_ram_rw;
  logic [1:0]  r_ram_dl;
  logic [8:0]  r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic        r_if_done;
  logic        r_d_done;
  logic        r_err;
  logic        r_busy;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic        w_ram_mov_nxt;
  logic        w_ram_rw_nxt;
  logic [1:0]  w_ram_dl_nxt;
  logic [8:0]  w_ram_addr_nxt;
  logic [31:0] w_ram_wdata_nxt;
  logic        w_if_done_nxt;
  logic        w_d_done_nxt;
  logic        w_err_nxt;
  logic [31:0] w_if_rdata_nxt;
  logic [31:0] w_d_rdata_nxt;

  logic        w_wd_clr;
  logic        w_wd_inc;
  logic        w_wd_tc;

  memory_arbiter_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .main_clk (main_clk),
    .reset    (reset),
    .i_clr    (w_wd_clr),
    .i_inc    (w_wd_inc),
    .o_tc     (w_wd_tc)
  );

  // On a tie the port that lost last time wins.
  assign w_grant = (if_req && d_req) ? ~r_last_grant : d_req;

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_winner_nxt     = r_winner;
    w_ram_mov_nxt    = r_ram_mov;
    w_ram_rw_nxt     = r_ram_rw;
    w_ram_dl_nxt     = r_ram_dl;
    w_ram_addr_nxt   = r_ram_addr;
    w_ram_wdata_nxt  = r_ram_wdata;
    w_if_done_nxt    = 1'b0;
    w_d_done_nxt     = 1'b0;
    w_err_nxt        = 1'b0;
    w_if_rdata_nxt   = r_if_rdata;
    w_d_rdata_nxt    = r_d_rdata;
    w_wd_clr         = 1'b0;
    w_wd_inc         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (if_req || d_req) begin
          w_winner_nxt  = w_grant;
          w_ram_mov_nxt = 1'b1;
          w_wd_clr      = 1'b1;
          w_state_nxt   = ST_ACCESS;
          if (w_grant == PORT_IF) begin
            w_ram_rw_nxt    = 1'b1;
            w_ram_dl_nxt    = DL_WORD;
            w_ram_addr_nxt  = if_addr;
            w_ram_wdata_nxt = 32'd0;
          end else begin
            w_ram_rw_nxt    = d_rw;
            w_ram_dl_nxt    = d_dl;
            w_ram_addr_nxt  = d_addr;
            w_ram_wdata_nxt = d_wdata;
          end
        end
      end
      ST_ACCESS: begin
        if (ram_moc) begin
          w_ram_mov_nxt = 1'b0;
          w_state_nxt   = ST_RESP;
          w_if_done_nxt = (r_winner == PORT_IF);
          w_d_done_nxt  = (r_winner == PORT_D);
          if (r_ram_rw && r_winner == PORT_IF) begin
            w_if_rdata_nxt = ram_rdata;
          end
          if (r_ram_rw && r_winner == PORT_D) begin
            w_d_rdata_nxt = ram_rdata;
          end
        end else if (w_wd_tc) begin
          w_ram_mov_nxt = 1'b0;
          w_state_nxt   = ST_RESP;
          w_err_nxt     = 1'b1;
          w_if_done_nxt = (r_winner == PORT_IF);
          w_d_done_nxt  = (r_winner == PORT_D);
          if (r_winner == PORT_IF) begin
            w_if_rdata_nxt = 32'd0;
          end else begin
            w_d_rdata_nxt = 32'd0;
          end
        end else begin
          w_wd_inc = 1'b1;
        end
      end
      ST_RESP: begin
        w_last_grant_nxt = r_winner;
        w_state_nxt      = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PORT_D;
      r_winner     <= PORT_IF;
      r_ram_mov    <= 1'b0;
      r_ram_rw     <= 1'b0;
      r_ram_dl     <= 2'b00;
      r_ram_addr   <= 9'd0;
      r_ram_wdata  <= 32'd0;
      r_if_done    <= 1'b0;
      r_d_done     <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_if_rdata   <= 32'd0;
      r_d_rdata    <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_winner     <= w_winner_nxt;
      r_ram_mov    <= w_ram_mov_nxt;
      r_ram_rw     <= w_ram_rw_nxt;
      r_ram_dl     <= w_ram_dl_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_wdata  <= w_ram_wdata_nxt;
      r_if_done    <= w_if_done_nxt;
      r_d_done     <= w_d_done_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_if_rdata   <= w_if_rdata_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
    end
  end

  assign ram_mov   = r_ram_mov;
  assign ram_rw    = r_ram_rw;
  assign ram_dl    = r_ram_dl;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign err       = r_err;
  assign busy      = r_busy;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed transactions,
// RAM responder model, command and completion monitors.
module tb_memory_arbiter;

  typedef struct {
    logic        rw;
    logic [1:0]  dl;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          movc;
  } rsp_t;

  logic        main_clk;
  logic        reset;
  logic        if_req;
  logic [8:0]  if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_dl;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        err;
  logic        busy;
  logic        ram_mov;
  logic        ram_rw;
  logic [1:0]  ram_dl;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_moc;
  logic [31:0] ram_rdata;

  memory_arbiter dut (
    .main_clk  (main_clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_rw      (d_rw),
    .d_dl      (d_dl),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .err       (err),
    .busy      (busy),
    .ram_mov   (ram_mov),
    .ram_rw    (ram_rw),
    .ram_dl    (ram_dl),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_moc   (ram_moc),
    .ram_rdata (ram_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int moc_wait = 0;
  int if_left = 0;
  int d_left = 0;
  int mov_run = 0;
  int mov_rise_cyc = 0;
  int done_cyc = 0;
  int req_cyc = 0;
  logic prev_mov = 1'b0;
  logic [31:0] mem [0:127];
  cmd_t cmd_q [$];
  rsp_t rsp_q [$];

  initial begin
    main_clk = 1'b0;
    forever #5 main_clk = ~main_clk;
  end

  always @(posedge main_clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_cmd(input logic rw,
                                   input logic [1:0] dl,
                                   input logic [8:0] addr,
                                   input logic [31:0] wdata);
    cmd_t c;
    c.rw = rw;
    c.dl = dl;
    c.addr = addr;
    c.wdata = wdata;
    cmd_q.push_back(c);
  endfunction

  function automatic void push_rsp(input logic port,
                                   input logic [31:0] rdata,
                                   input logic e,
                                   input int movc);
    rsp_t r;
    r.port = port;
    r.rdata = rdata;
    r.err = e;
    r.movc = movc;
    rsp_q.push_back(r);
  endfunction

  // RAM responder: completes moc_wait cycles into the access,
  // never if moc_wait is negative; junk data outside completion.
  initial begin : ram_model
    int acc;
    acc = 0;
    ram_moc = 1'b0;
    ram_rdata = 32'hBAD0BAD0;
    forever begin
      @(posedge main_clk);
      #1;
      if (ram_mov === 1'b1) begin
        acc++;
        ram_moc = (moc_wait >= 0) && (acc == moc_wait + 1);
      end else begin
        acc = 0;
        ram_moc = 1'b0;
      end
      ram_rdata = ram_moc ? mem[ram_addr[8:2]] : 32'hBAD0BAD0;
    end
  end

  // Requesters hold req while transactions remain and drop it
  // at the edge ending their final done cycle.
  initial begin : requester
    if_req = 1'b0;
    d_req = 1'b0;
    forever begin
      @(negedge main_clk);
      if (if_done === 1'b1 && if_left > 0) if_left--;
      if (d_done === 1'b1 && d_left > 0) d_left--;
      @(posedge main_clk);
      #1;
      if_req = (if_left > 0);
      d_req = (d_left > 0);
    end
  end

  initial begin : monitor
    cmd_t c;
    rsp_t r;
    forever begin
      @(negedge main_clk);
      if (ram_mov === 1'b1 && !prev_mov) begin
        mov_rise_cyc = cyc;
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mov: got addr %h expected none",
                   ram_addr);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_rw", ram_rw, c.rw);
          chk("cmd_dl", ram_dl, c.dl);
          chk("cmd_addr", ram_addr, c.addr);
          chk("cmd_wdata", ram_wdata, c.wdata);
        end
      end
      if (ram_mov === 1'b1) mov_run = prev_mov ? mov_run + 1 : 1;
      if (err === 1'b1 && if_done !== 1'b1 && d_done !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL err_without_done: got 1 expected 0");
      end
      if (if_done === 1'b1 || d_done === 1'b1) begin
        done_cyc = cyc;
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got if %b d %b expected none",
                   if_done, d_done);
        end else begin
          r = rsp_q.pop_front();
          chk("done_onehot", if_done & d_done, 0);
          chk("done_port", d_done, r.port);
          chk("rdata", d_done ? d_rdata : if_rdata, r.rdata);
          chk("err", err, r.err);
          chk("mov_cycles", mov_run, r.movc);
          chk("done_after_mov", {prev_mov, ram_mov}, 2'b10);
        end
      end
      prev_mov = (ram_mov === 1'b1);
    end
  end

  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || if_left != 0 || d_left != 0 ||
            busy !== 1'b0) && n < budget) begin
      @(negedge main_clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d cycles expected < %0d",
               name, n, budget);
    end
  endtask

  task automatic pulse_reset();
    @(negedge main_clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge main_clk);
    #1 reset = 1'b0;
  endtask

  initial begin : stim
    int n;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[4]  = 32'hE3A01005;
    mem[5]  = 32'h12345678;
    mem[8]  = 32'hCAFEF00D;
    mem[9]  = 32'hA5A55A5A;
    mem[10] = 32'h77777777;
    mem[11] = 32'h0C0FFEE0;
    reset = 1'b1;
    if_addr = 9'd0;
    d_rw = 1'b1;
    d_dl = 2'b10;
    d_addr = 9'd0;
    d_wdata = 32'd0;

    // reset state
    repeat (2) @(posedge main_clk);
    @(negedge main_clk);
    chk("rst_ram_mov", ram_mov, 0);
    chk("rst_ram_rw", ram_rw, 0);
    chk("rst_ram_dl", ram_dl, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    #1 reset = 1'b0;

    // single zero-wait fetch with latency
    @(negedge main_clk);
    #1;
    moc_wait = 0;
    if_addr = 9'h010;
    push_cmd(1'b1, 2'b10, 9'h010, 32'h0);
    push_rsp(1'b0, 32'hE3A01005, 1'b0, 1);
    if_left = 1;
    @(posedge main_clk);
    #1 req_cyc = cyc;
    wait_quiet("fetch", 20);
    chk("mov_latency", mov_rise_cyc - req_cyc, 1);
    chk("done_latency", done_cyc - req_cyc, 2);

    // tie from reset: fetch first, then a write
    @(negedge main_clk);
    #1 reset = 1'b1;
    if_addr = 9'h014;
    d_rw = 1'b0;
    d_dl = 2'b10;
    d_addr = 9'h020;
    d_wdata = 32'hDEADBEEF;
    push_cmd(1'b1, 2'b10, 9'h014, 32'h0);
    push_rsp(1'b0, 32'h12345678, 1'b0, 1);
    push_cmd(1'b0, 2'b10, 9'h020, 32'hDEADBEEF);
    push_rsp(1'b1, 32'h0, 1'b0, 1);
    if_left = 1;
    d_left = 1;
    repeat (2) @(negedge main_clk);
    #1 reset = 1'b0;
    wait_quiet("tie", 30);

    // continuous contention alternates F,D,F,D,F,D
    @(negedge main_clk);
    #1;
    moc_wait = 1;
    if_addr = 9'h010;
    d_rw = 1'b1;
    d_dl = 2'b01;
    d_addr = 9'h024;
    d_wdata = 32'h55AA55AA;
    for (int k = 0; k < 3; k++) begin
      push_cmd(1'b1, 2'b10, 9'h010, 32'h0);
      push_rsp(1'b0, 32'hE3A01005, 1'b0, 2);
      push_cmd(1'b1, 2'b01, 9'h024, 32'h55AA55AA);
      push_rsp(1'b1, 32'hA5A55A5A, 1'b0, 2);
    end
    if_left = 3;
    d_left = 3;
    wait_quiet("alternate", 80);

    // read that never completes: watchdog abort
    @(negedge main_clk);
    #1;
    moc_wait = -1;
    d_rw = 1'b1;
    d_dl = 2'b10;
    d_addr = 9'h028;
    d_wdata = 32'h0;
    push_cmd(1'b1, 2'b10, 9'h028, 32'h0);
    push_rsp(1'b1, 32'h0, 1'b1, 15);
    d_left = 1;
    wait_quiet("abort", 60);

    // fetch so fetch becomes last grant
    @(negedge main_clk);
    #1;
    moc_wait = 0;
    if_addr = 9'h010;
    push_cmd(1'b1, 2'b10, 9'h010, 32'h0);
    push_rsp(1'b0, 32'hE3A01005, 1'b0, 1);
    if_left = 1;
    wait_quiet("fetch2", 20);

    // reset in the second ACCESS cycle of a stalled read
    @(negedge main_clk);
    #1;
    moc_wait = -1;
    d_addr = 9'h02C;
    push_cmd(1'b1, 2'b10, 9'h02C, 32'h0);
    d_left = 1;
    n = 0;
    while (ram_mov !== 1'b1 && n < 10) begin
      @(negedge main_clk);
      n++;
    end
    chk("abort_mov_seen", ram_mov, 1);
    d_left = 0;
    @(negedge main_clk);
    #1 reset = 1'b1;
    @(negedge main_clk);
    chk("rst_acc_mov", ram_mov, 0);
    chk("rst_acc_busy", busy, 0);
    chk("rst_acc_d_done", d_done, 0);
    chk("rst_acc_d_rdata", d_rdata, 0);
    chk("rst_acc_if_rdata", if_rdata, 0);
    #1 reset = 1'b0;
    repeat (4) @(negedge main_clk);
    #1;
    moc_wait = 0;
    if_addr = 9'h014;
    push_cmd(1'b1, 2'b10, 9'h014, 32'h0);
    push_rsp(1'b0, 32'h12345678, 1'b0, 1);
    push_cmd(1'b1, 2'b10, 9'h02C, 32'h0);
    push_rsp(1'b1, 32'h0C0FFEE0, 1'b0, 1);
    if_left = 1;
    d_left = 1;
    wait_quiet("post_reset_tie", 30);

    repeat (3) @(negedge main_clk);
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench stalled");
  end

endmodule
